// File: rtl/reg_file.sv
// 32 x 32-bit RISC-V integer register file: two combinational read ports and
// one synchronous write port, x0 hard-wired to zero, optional write-to-read bypass.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] RW,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [DATA_W-1:0] busW,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB
);

    localparam int NumRegs = 1 << ADDR_W;

    // Power-up contents are zero so the read ports never show X before the first reset.
    logic [DATA_W-1:0] regBank [NumRegs] = '{default: '0};

    logic writeHit;
    logic bypassA;
    logic bypassB;

    assign writeHit = write_en && (RW != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regBank[i] <= '0;
            end
        end else if (writeHit) begin
            regBank[RW] <= busW;
        end
    end

    // Index 0 is decoded on the read side so x0 reads zero regardless of storage.
    always_comb begin
        bypassA = (BYPASS != 0) && writeHit && (RW == RA);
        bypassB = (BYPASS != 0) && writeHit && (RW == RB);

        if (RA == '0) begin
            busA = '0;
        end else if (bypassA) begin
            busA = busW;
        end else begin
            busA = regBank[RA];
        end

        if (RB == '0) begin
            busB = '0;
        end else if (bypassB) begin
            busB = busW;
        end else begin
            busB = regBank[RB];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a plain-array model drives expectations for
// one non-bypass and one bypass instance sharing the same stimulus.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_en = 1'b0;
    logic [4:0]  RW = '0;
    logic [4:0]  RA = '0;
    logic [4:0]  RB = '0;
    logic [31:0] busW = '0;
    logic [31:0] busA0, busB0, busA1, busB1;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] modelRegs [32];

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dutPlain (
        .clk(clk), .rst(rst), .write_en(write_en), .RW(RW), .RA(RA), .RB(RB),
        .busW(busW), .busA(busA0), .busB(busB0)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dutBypass (
        .clk(clk), .rst(rst), .write_en(write_en), .RW(RW), .RA(RA), .RB(RB),
        .busW(busW), .busA(busA1), .busB(busB1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural view: x0 is zero, bypass forwards busW on a live write hit.
    function automatic logic [31:0] readExp(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp && write_en && RW != 5'd0 && RW == a) return busW;
        return modelRegs[a];
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".A0"}, busA0, readExp(1'b0, RA));
        checkOutput({tag, ".B0"}, busB0, readExp(1'b0, RB));
        checkOutput({tag, ".A1"}, busA1, readExp(1'b1, RA));
        checkOutput({tag, ".B1"}, busB1, readExp(1'b1, RB));
    endtask

    // Drive one cycle, check before and after the committing edge.
    task automatic applyStimulus(input string tag, input logic r, input logic we,
                                 input logic [4:0] rw, input logic [31:0] w,
                                 input logic [4:0] ra, input logic [4:0] rb);
        rst = r; write_en = we; RW = rw; busW = w; RA = ra; RB = rb;
        #1;
        checkAll({tag, ".pre"});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        end else if (we && rw != 5'd0) begin
            modelRegs[rw] = w;
        end
        #1;
        checkAll({tag, ".post"});
        rst = 1'b0; write_en = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        @(negedge clk);

        RA = 5'd5; RB = 5'd31;
        #1;
        checkOutput("powerup.A", busA0, 32'd0);
        checkOutput("powerup.B", busB0, 32'd0);

        applyStimulus("reset", 1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
        checkOutput("reset.A", busA0, 32'd0);
        checkOutput("reset.B", busB1, 32'd0);

        applyStimulus("wr1", 1'b0, 1'b1, 5'd1, 32'd12, 5'd1, 5'd0);
        checkOutput("wr1.A", busA0, 32'd12);

        for (int k = 0; k < 10; k++) begin
            busW = $urandom;
            RA = 5'd1;
            repeat (10) @(posedge clk);
            #1;
            checkOutput("hold.A0", busA0, 32'd12);
            checkOutput("hold.A1", busA1, 32'd12);
        end

        applyStimulus("wr2", 1'b0, 1'b1, 5'd2, 32'd14, 5'd1, 5'd2);
        checkOutput("wr2.B", busB0, 32'd14);
        checkOutput("wr2.A", busA0, 32'd12);

        applyStimulus("x0", 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        checkOutput("x0.A0", busA0, 32'd0);
        checkOutput("x0.A1", busA1, 32'd0);

        rst = 1'b1; write_en = 1'b1; RW = 5'd1; busW = 32'd99; RA = 5'd1; RB = 5'd2;
        @(posedge clk);
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        #1;
        rst = 1'b0; write_en = 1'b0;
        #1;
        checkOutput("rstwr.A0", busA0, 32'd0);
        checkOutput("rstwr.A1", busA1, 32'd0);
        checkOutput("rstwr.B0", busB0, 32'd0);

        rst = 1'b0; write_en = 1'b1; RW = 5'd3; busW = 32'd7; RA = 5'd3; RB = 5'd3;
        #1;
        checkOutput("byp.pre.A1", busA1, 32'd7);
        checkOutput("byp.pre.A0", busA0, 32'd0);
        @(posedge clk);
        modelRegs[3] = 32'd7;
        #1;
        write_en = 1'b0;
        #1;
        checkOutput("byp.post.A0", busA0, 32'd7);
        checkOutput("byp.post.B0", busB0, 32'd7);

        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        we;
            logic [4:0]  rw, ra, rb;
            logic [31:0] w;
            r  = ($urandom_range(0, 40) == 0);
            we = ($urandom_range(0, 3) != 0);
            rw = 5'($urandom_range(0, 31));
            w  = $urandom;
            ra = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            applyStimulus("rand", r, we, rw, w, ra, rb);
        end

        for (int i = 0; i < 32; i++) begin
            applyStimulus("sweep", 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
